// File: rtl/keypad_scan_encoder_if.sv
// Keypad-side and consumer-side signals of the scan encoder.
// The master modport is the encoder; slave is the keypad/consumer.
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       btn_valid;
   logic [7:0] btn_char;
   logic       key_held;

   modport master (input row_in, output col_out, btn_valid, btn_char, key_held);
   modport slave  (output row_in, input col_out, btn_valid, btn_char, key_held);
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner with debounced press/release detection.
// Emits a one-cycle strobe carrying the ASCII code of each accepted key.
module keypad_scan_encoder #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   keypad_if.master kp
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] S_SCAN     = 2'd0;
   localparam logic [1:0] S_DEBOUNCE = 2'd1;
   localparam logic [1:0] S_PRESSED  = 2'd2;
   localparam logic [1:0] S_RELEASE  = 2'd3;

   logic [3:0]       row_sync_p0;
   logic [3:0]       row_sync_p1;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       state;
   logic [1:0]       col_q;
   logic [1:0]       row_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_valid_q;
   logic [7:0]       btn_char_q;
   logic             sample;
   logic             hit;
   logic [1:0]       hit_row;
   logic             same_key;
   logic             row_released;

   function automatic logic [7:0] key_char(input logic [1:0] r, input logic [1:0] c);
      logic [7:0] ch;
      case ({r, c})
         4'h0: ch = "1";  4'h1: ch = "2";  4'h2: ch = "3";  4'h3: ch = "+";
         4'h4: ch = "4";  4'h5: ch = "5";  4'h6: ch = "6";  4'h7: ch = "-";
         4'h8: ch = "7";  4'h9: ch = "8";  4'hA: ch = "9";  4'hB: ch = "*";
         4'hC: ch = "C";  4'hD: ch = "0";  4'hE: ch = "=";  default: ch = 8'h00;
      endcase
      return ch;
   endfunction

   // Lowest low row in the driven column wins; the r3/c3 position is unpopulated.
   always_comb begin
      hit     = 1'b0;
      hit_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_sync_p1[r] && !(r == 3 && col_q == 2'd3)) begin
            hit     = 1'b1;
            hit_row = 2'(r);
         end
      end
   end

   assign sample       = (div_q == DIV_LAST);
   assign same_key     = hit && (hit_row == row_q);
   assign row_released = row_sync_p1[row_q];

   // Stage p0/p1: metastability guard on the asynchronous rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_sync_p0 <= 4'hF;
         row_sync_p1 <= 4'hF;
      end else begin
         row_sync_p0 <= kp.row_in;
         row_sync_p1 <= row_sync_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q       <= '0;
         state       <= S_SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         btn_valid_q <= 1'b0;
         btn_char_q  <= 8'h00;
      end else begin
         btn_valid_q <= 1'b0;
         div_q       <= sample ? '0 : div_q + 1'b1;
         if (sample) begin
            case (state)
               S_SCAN: begin
                  if (hit) begin
                     row_q <= hit_row;
                     cnt_q <= CNT_W'(1);
                     state <= S_DEBOUNCE;
                  end else begin
                     col_q <= col_q + 2'd1;
                  end
               end
               S_DEBOUNCE: begin
                  if (!same_key) begin
                     state <= S_SCAN;
                     col_q <= col_q + 2'd1;
                  end else if (cnt_q == CNT_LAST) begin
                     state       <= S_PRESSED;
                     btn_valid_q <= 1'b1;
                     btn_char_q  <= key_char(row_q, col_q);
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_PRESSED: begin
                  if (row_released) begin
                     cnt_q <= CNT_W'(1);
                     state <= S_RELEASE;
                  end
               end
               default: begin
                  // A bounce back to low returns to PRESSED without a new strobe.
                  if (!row_released) begin
                     state <= S_PRESSED;
                  end else if (cnt_q == CNT_LAST) begin
                     state <= S_SCAN;
                     col_q <= col_q + 2'd1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign kp.col_out   = ~(4'b0001 << col_q);
   assign kp.btn_valid = btn_valid_q;
   assign kp.btn_char  = btn_char_q;
   assign kp.key_held  = (state == S_PRESSED) || (state == S_RELEASE);
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad matrix model drives the rows,
// a sample-level reference model is compared against the outputs every cycle.
module tb_keypad_scan_encoder;
   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pressed = '0;   // bit r*4+c set = key at row r, column c is down

   keypad_if kif ();

   keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kif.master)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] keypad_rows(input logic [15:0] pm, input logic [3:0] cols);
      logic [3:0] rows;
      rows = 4'hF;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (pm[i*4+j] && !cols[j]) rows[i] = 1'b0;
      return rows;
   endfunction

   assign kif.row_in = keypad_rows(pressed, kif.col_out);

   int n_checks = 0;
   int n_errors = 0;
   string cur_test = "init";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s/%s actual=%h expected=%h", cur_test, name, act, exp);
      end
   endtask

   // Reference model: keypad as seen two edges late, evaluated once per scan period.
   string      KEYMAP = "123+456-789*C0=?";
   logic [3:0] m_sync [2];
   int         m_tick;
   logic [1:0] m_col;
   int         m_phase;   // 0 scanning, 1 confirming, 2 held, 3 releasing
   int         m_row;
   int         m_n;
   logic       m_valid;
   logic [7:0] m_char;

   task automatic m_reset();
      m_sync[0] = 4'hF; m_sync[1] = 4'hF;
      m_tick = 0; m_col = 2'd0; m_phase = 0; m_row = 0; m_n = 0;
      m_valid = 1'b0; m_char = 8'h00;
   endtask

   task automatic m_step();
      logic [3:0] seen;
      int hr;
      if (!rst_n) begin
         m_reset();
         return;
      end
      seen = m_sync[1];
      m_sync[1] = m_sync[0];
      m_sync[0] = keypad_rows(pressed, ~(4'b0001 << m_col));
      m_valid = 1'b0;
      if (m_tick % SD == SD - 1) begin
         hr = -1;
         for (int r = 0; r < 4; r++)
            if (hr < 0 && !seen[r] && !(r == 3 && m_col == 2'd3)) hr = r;
         case (m_phase)
            0: if (hr >= 0) begin m_row = hr; m_n = 1; m_phase = 1; end
               else m_col = m_col + 2'd1;
            1: if (hr == m_row) begin
                  m_n++;
                  if (m_n == DB) begin
                     m_phase = 2; m_valid = 1'b1;
                     m_char = KEYMAP[m_row*4 + int'(m_col)];
                  end
               end else begin
                  m_phase = 0; m_col = m_col + 2'd1;
               end
            2: if (seen[m_row]) begin m_phase = 3; m_n = 1; end
            default: if (!seen[m_row]) m_phase = 2;
               else begin
                  m_n++;
                  if (m_n == DB) begin m_phase = 0; m_col = m_col + 2'd1; end
               end
         endcase
      end
      m_tick++;
   endtask

   task automatic compare(input string name);
      check(name, {18'd0, kif.col_out, kif.key_held, kif.btn_valid, kif.btn_char},
            {18'd0, ~(4'b0001 << m_col), (m_phase >= 2), m_valid, m_char});
   endtask

   int         n_strobe;
   int         n_match;
   logic [7:0] exp_char;
   logic       held_seen;
   logic [3:0] cols_seen;

   task automatic clear_obs(input logic [7:0] ch);
      n_strobe = 0; n_match = 0; exp_char = ch; held_seen = 1'b0; cols_seen = 4'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      compare("cycle");
      if (kif.btn_valid) begin
         n_strobe++;
         if (kif.btn_char == exp_char) n_match++;
      end
      if (kif.key_held) held_seen = 1'b1;
      cols_seen |= ~kif.col_out;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous assertion mid-cycle, checked immediately, released #1 after an edge.
   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_col", {28'd0, kif.col_out}, 32'hE);
      check("rst_out", {22'd0, kif.btn_valid, kif.key_held, kif.btn_char}, 32'h0);
      ticks(2);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] keys;
      int          hold;
      int          exp_n;
      logic [7:0]  exp_ch;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{16'h0040,   40, 1, 8'h36};   // "6"
      vecs[1] = '{16'h4000, 1000, 1, 8'h3D};   // "=" held long
      vecs[2] = '{16'h0101,   40, 1, 8'h31};   // "1" and "7" together
      vecs[3] = '{16'h8000,   40, 0, 8'h00};   // reserved position
      vecs[4] = '{16'h0008,   40, 1, 8'h2B};   // "+"
      vecs[5] = '{16'h1000,   40, 1, 8'h43};   // "C"
      vecs[6] = '{16'h0800,   40, 1, 8'h2A};   // "*"
      vecs[7] = '{16'h2000,   40, 1, 8'h30};   // "0"

      m_reset();
      cur_test = "table";
      for (int v = 0; v < 8; v++) begin
         apply_reset();
         clear_obs(vecs[v].exp_ch);
         pressed = vecs[v].keys;
         ticks(vecs[v].hold);
         pressed = '0;
         ticks(40);
         check("strobes", n_strobe, vecs[v].exp_n);
         check("char", {24'd0, kif.btn_char}, {24'd0, vecs[v].exp_ch});
         check("released", {31'd0, kif.key_held}, 32'd0);
      end

      // Latency and release debounce of "6"
      cur_test = "latency";
      apply_reset();
      clear_obs(8'h36);
      pressed = 16'h0040;
      ticks(27);
      check("strobe_in_27", n_strobe, 1);
      check("char6", n_match, 1);
      ticks(3);
      pressed = '0;
      ticks(13);
      check("held_during_rel", {31'd0, kif.key_held}, 32'd1);
      tick();
      check("held_after_rel", {31'd0, kif.key_held}, 32'd0);

      // Two samples of "1" then released: no strobe, scan moves on to column 1
      cur_test = "bounce";
      apply_reset();
      clear_obs(8'h31);
      pressed = 16'h0001;
      ticks(8);
      pressed = '0;
      ticks(4);
      check("col_next", {28'd0, kif.col_out}, 32'hD);
      check("no_strobe", n_strobe, 0);

      // Long hold, release, second press of "="
      cur_test = "repress";
      apply_reset();
      clear_obs(8'h3D);
      pressed = 16'h4000;
      ticks(1000);
      pressed = '0;
      ticks(40);
      pressed = 16'h4000;
      ticks(60);
      pressed = '0;
      ticks(40);
      check("two_strobes", n_strobe, 2);
      check("both_eq", n_match, 2);

      // Multi-row priority, then a second key while "1" is held
      cur_test = "priority";
      apply_reset();
      clear_obs(8'h31);
      pressed = 16'h0101;
      ticks(40);
      check("one_strobe", n_strobe, 1);
      check("char1", n_match, 1);
      pressed = 16'h0121;
      ticks(60);
      check("ignored", n_strobe, 1);
      check("still_held", {31'd0, kif.key_held}, 32'd1);
      pressed = '0;
      ticks(40);

      // Reserved position only
      cur_test = "reserved";
      apply_reset();
      clear_obs(8'h00);
      pressed = 16'h8000;
      ticks(40);
      check("none", n_strobe, 0);
      check("never_held", {31'd0, held_seen}, 32'd0);
      check("rotating", {28'd0, cols_seen}, 32'hF);
      pressed = '0;

      // Reset during debounce of "5"
      cur_test = "rst_debounce";
      apply_reset();
      clear_obs(8'h35);
      pressed = 16'h0020;
      ticks(13);
      apply_reset();
      ticks(SD);
      check("quiet_first_pass", n_strobe, 0);
      ticks(30);
      check("redetect", n_strobe, 1);
      check("char5", n_match, 1);
      pressed = '0;
      ticks(40);

      // Random presses, bounces and resets against the model
      cur_test = "random";
      apply_reset();
      clear_obs(8'h00);
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 24) == 0) apply_reset();
         case ($urandom_range(0, 3))
            0: pressed = '0;
            1, 2: pressed = 16'h1 << $urandom_range(0, 15);
            default: pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         endcase
         ticks($urandom_range(1, 50));
         if ($urandom_range(0, 1) == 1) begin
            pressed = '0;
            ticks($urandom_range(1, 30));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/keypad_scan_encoder.md
KEYPAD_SCAN_ENCODER -- requirements
Module: keypad_scan_encoder

Interface
REQ-001 Parameter SCAN_DIV, 1000: clk cycles each column stays driven; legal range >= 4.
REQ-002 Parameter DEBOUNCE_CNT, 8: consecutive matching samples needed to accept a press or release; legal range >= 2.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 row_in  input  4  keypad rows, active-low (pulled up); asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 btn_valid  output  1  one-cycle strobe: btn_char carries a new accepted key.
REQ-008 btn_char  output  8  ASCII code of last accepted key; held between strobes.
REQ-009 key_held  output  1  high while an accepted key is down or its release is being debounced.

Function
REQ-010 row_in shall pass through a 2-flop synchronizer before any use.
REQ-011 Divider counts 0..SCAN_DIV-1 continuously; the sample point is the cycle with divider = SCAN_DIV-1, when synchronized rows are evaluated for the currently driven column.
REQ-012 Key map [row][col]: r0 "1","2","3","+"; r1 "4","5","6","-"; r2 "7","8","9","*"; r3 "C","0","=",reserved. Reserved position is never detected.
REQ-013 Multiple low rows in one column: lowest row index wins; other columns are not considered until return to SCAN.
REQ-014 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 SCAN: at each sample point, no valid key -> advance column 0->1->2->3->0. Valid key -> latch row/col, stable count = 1, go DEBOUNCE, column frozen.
REQ-016 DEBOUNCE: at each sample, same key low -> count+1. When count reaches DEBOUNCE_CNT -> go PRESSED and assert btn_valid the next cycle with btn_char updated the same cycle. Different or no key -> go SCAN at next column, no strobe.
REQ-017 PRESSED: key_held = 1. Latched row high at sample -> go RELEASE, release count = 1. Other keys pressed meanwhile are ignored.
REQ-018 RELEASE: latched row high at sample -> count+1. Reaching DEBOUNCE_CNT -> go SCAN at next column, key_held = 0. Latched row low -> back to PRESSED, no new strobe.
REQ-019 Exactly one btn_valid per accepted press regardless of hold duration; btn_valid never asserted two consecutive cycles.
REQ-020 Latency from stable row_in to btn_valid <= (DEBOUNCE_CNT+3)*SCAN_DIV + 3 cycles.
REQ-021 No backpressure: consumer samples btn_char on btn_valid; output does not wait.

Reset
REQ-022 While rst_n low: col_out = 4'b1110, btn_valid = 0, btn_char = 8'h00, key_held = 0, state SCAN, divider and counters 0, synchronizer flops 4'hF.
REQ-023 Reset mid-operation (any state) discards the pending key; no strobe is produced for it after release of reset.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-024 Hold r1/c2 low stable -> exactly one btn_valid with btn_char = 8'h36 ("6") within 27 cycles; key_held high until 3 release samples after release.
REQ-025 r0/c0 low for 2 samples then high (bounce) -> no btn_valid; scanning resumes at column 1.
REQ-026 Hold r3/c2 for 1000 cycles, release, press again -> exactly two strobes, both btn_char = 8'h3D ("=").
REQ-027 r0/c0 and r2/c0 low together -> single strobe btn_char = 8'h31 ("1"); a later press of r1/c1 while "1" is held -> no strobe.
REQ-028 r3/c3 held low only -> no btn_valid, key_held stays 0, col_out keeps rotating.
REQ-029 rst_n pulsed low during DEBOUNCE of "5" -> outputs at REQ-022 values immediately; no strobe while the key stays held through the end of reset's first column pass; normal detection follows.
